// File: rtl/fnd_scan_controller.sv
// ----------------------------------------------------------------------------
// fnd_scan_controller
//
// Upstream stage of the 4-digit FND decoder. A load request captures a 14-bit
// binary value (clamped to 9999), converts it to four BCD digits with a
// sequential shift-add-3 engine, and publishes the result atomically to a
// display register. A free-running scan divider walks the digit index across
// the shared BCD bus, with optional leading-zero blanking.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        synchronous active-high reset
//   i_value[13:0]  binary value to display (nominally 0..9999)
//   i_load         single-cycle capture/convert request (ignored while busy)
//   i_en           global display enable
//   o_digitSelect  selected digit index, 0 = ones .. 3 = thousands
//   o_bcd[3:0]     BCD value of the selected digit
//   o_en           decoder enable for the selected digit
//   o_busy         conversion in progress
//   o_overflow     last accepted load exceeded 9999 and was clamped
// ----------------------------------------------------------------------------
module fnd_scan_controller #(
    parameter int unsigned CLK_HZ   = 100000000,
    parameter int unsigned SCAN_HZ  = 1000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [13:0] i_value,
    input  logic        i_load,
    input  logic        i_en,
    output logic [1:0]  o_digitSelect,
    output logic [3:0]  o_bcd,
    output logic        o_en,
    output logic        o_busy,
    output logic        o_overflow
);

    localparam int unsigned DIV      = CLK_HZ / SCAN_HZ;
    localparam int unsigned CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [13:0] MAX_VAL  = 14'd9999;
    localparam logic [3:0]  LAST_SHIFT = 4'd13;

    typedef enum logic [1:0] {
        StIdle,
        StConvert,
        StDone
    } state_e;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e           r_state;
    logic [13:0]      r_operand;
    logic [15:0]      r_bcd;
    logic [3:0]       r_shift_cnt;
    logic [15:0]      r_display;
    logic             r_overflow;
    logic [CNT_W-1:0] r_scan_cnt;
    logic [1:0]       r_digit_sel;

    // ------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------
    state_e      w_state_next;
    logic [13:0] w_operand_next;
    logic [15:0] w_bcd_next;
    logic [3:0]  w_shift_cnt_next;
    logic [15:0] w_display_next;
    logic        w_overflow_next;
    logic [14:0] w_bcd_adj;
    logic [3:0]  w_blank;

    // Add-3 correction on the ones, tens and hundreds nibbles. With the
    // operand clamped to 9999 the thousands nibble is at most 4 before every
    // shift, so it never needs correction and its top bit is always shifted
    // out as zero.
    always_comb begin
        w_bcd_adj = r_bcd[14:0];
        for (int k = 0; k < 3; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) begin
                w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    // ------------------------------------------------------------------
    // Conversion FSM: next state and datapath updates
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_operand_next   = r_operand;
        w_bcd_next       = r_bcd;
        w_shift_cnt_next = r_shift_cnt;
        w_display_next   = r_display;
        w_overflow_next  = r_overflow;

        unique case (r_state)
            StIdle: begin
                if (i_load) begin
                    if (i_value > MAX_VAL) begin
                        w_operand_next  = MAX_VAL;
                        w_overflow_next = 1'b1;
                    end else begin
                        w_operand_next  = i_value;
                        w_overflow_next = 1'b0;
                    end
                    w_bcd_next       = 16'h0000;
                    w_shift_cnt_next = 4'd0;
                    w_state_next     = StConvert;
                end
            end

            StConvert: begin
                {w_bcd_next, w_operand_next} = {w_bcd_adj, r_operand, 1'b0};
                w_shift_cnt_next             = r_shift_cnt + 4'd1;
                if (r_shift_cnt == LAST_SHIFT) begin
                    w_state_next = StDone;
                end
            end

            StDone: begin
                // Single-cycle publish keeps partial results off the display.
                w_display_next = r_bcd;
                w_state_next   = StIdle;
            end

            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_operand   <= 14'd0;
            r_bcd       <= 16'h0000;
            r_shift_cnt <= 4'd0;
            r_display   <= 16'h0000;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_operand   <= w_operand_next;
            r_bcd       <= w_bcd_next;
            r_shift_cnt <= w_shift_cnt_next;
            r_display   <= w_display_next;
            r_overflow  <= w_overflow_next;
        end
    end

    // ------------------------------------------------------------------
    // Scan divider: free-running, independent of i_en and the FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_scan_cnt  <= '0;
            r_digit_sel <= 2'd0;
        end else if (r_scan_cnt == CNT_LAST) begin
            r_scan_cnt  <= '0;
            r_digit_sel <= r_digit_sel + 2'd1;
        end else begin
            r_scan_cnt  <= r_scan_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero blanking: digit k is blank when all nibbles >= k are zero
    // ------------------------------------------------------------------
    always_comb begin
        w_blank    = 4'b0000;
        w_blank[1] = BLANK_LZ && (r_display[15:4] == 12'h000);
        w_blank[2] = BLANK_LZ && (r_display[15:8] == 8'h00);
        w_blank[3] = BLANK_LZ && (r_display[15:12] == 4'h0);
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        o_bcd = 4'h0;
        unique case (r_digit_sel)
            2'd0:    o_bcd = r_display[3:0];
            2'd1:    o_bcd = r_display[7:4];
            2'd2:    o_bcd = r_display[11:8];
            2'd3:    o_bcd = r_display[15:12];
            default: o_bcd = 4'h0;
        endcase
    end

    assign o_digitSelect = r_digit_sel;
    assign o_en          = i_en & ~w_blank[r_digit_sel];
    assign o_busy        = (r_state != StIdle);
    assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// ----------------------------------------------------------------------------
// tb_fnd_scan_controller
//
// Two instances (leading-zero blanking on / off) share stimulus. Expected
// digits, enables and scan position come from decimal arithmetic on the
// clamped value and the number of clock edges since the last reset.
// ----------------------------------------------------------------------------
module tb_fnd_scan_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] value;
    logic        load;
    logic        en;

    logic [1:0] sel_a, sel_b;
    logic [3:0] bcd_a, bcd_b;
    logic       en_a, en_b, busy_a, busy_b, ovf_a, ovf_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    int m_val = 0;
    bit m_ovf = 1'b0;
    int m_n   = 0;

    always #5 clk = ~clk;

    fnd_scan_controller #(.CLK_HZ(1000), .SCAN_HZ(250), .BLANK_LZ(1'b1)) dut_blz (
        .i_clk(clk), .i_reset(rst), .i_value(value), .i_load(load), .i_en(en),
        .o_digitSelect(sel_a), .o_bcd(bcd_a), .o_en(en_a), .o_busy(busy_a),
        .o_overflow(ovf_a)
    );

    fnd_scan_controller #(.CLK_HZ(1000), .SCAN_HZ(250), .BLANK_LZ(1'b0)) dut_all (
        .i_clk(clk), .i_reset(rst), .i_value(value), .i_load(load), .i_en(en),
        .o_digitSelect(sel_b), .o_bcd(bcd_b), .o_en(en_b), .o_busy(busy_b),
        .o_overflow(ovf_b)
    );

    // Edges since the last reset edge; DIV = 4 so the index is (n / 4) mod 4.
    always @(posedge clk) begin
        if (rst) m_n <= 0;
        else     m_n <= m_n + 1;
    end

    function automatic int pow10(input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    function automatic int exp_digit(input int v, input int k);
        return (v / pow10(k)) % 10;
    endfunction

    function automatic bit exp_en(input int v, input int k, input bit blz, input bit e);
        if (!e) return 1'b0;
        if (!blz || k == 0) return 1'b1;
        return v >= pow10(k);
    endfunction

    function automatic int exp_sel();
        return (m_n / 4) % 4;
    endfunction

    // Observe the idle display for a number of cycles, optionally toggling i_en.
    task automatic run_scan(input string tag, input int cycles, input bit rand_en);
        int s;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            en = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            s = exp_sel();
            n_checks++; if (sel_a !== 2'(s)) begin n_fail++; $display("FAIL %s sel_a c=%0d got=%0d exp=%0d", tag, c, sel_a, s); end
            n_checks++; if (sel_b !== 2'(s)) begin n_fail++; $display("FAIL %s sel_b c=%0d got=%0d exp=%0d", tag, c, sel_b, s); end
            n_checks++; if (bcd_a !== 4'(exp_digit(m_val, s))) begin n_fail++; $display("FAIL %s bcd_a c=%0d got=%0d exp=%0d", tag, c, bcd_a, exp_digit(m_val, s)); end
            n_checks++; if (bcd_b !== 4'(exp_digit(m_val, s))) begin n_fail++; $display("FAIL %s bcd_b c=%0d got=%0d exp=%0d", tag, c, bcd_b, exp_digit(m_val, s)); end
            n_checks++; if (en_a !== exp_en(m_val, s, 1'b1, en)) begin n_fail++; $display("FAIL %s en_a c=%0d got=%0b exp=%0b", tag, c, en_a, exp_en(m_val, s, 1'b1, en)); end
            n_checks++; if (en_b !== exp_en(m_val, s, 1'b0, en)) begin n_fail++; $display("FAIL %s en_b c=%0d got=%0b exp=%0b", tag, c, en_b, exp_en(m_val, s, 1'b0, en)); end
            n_checks++; if ({busy_a, busy_b} !== 2'b00) begin n_fail++; $display("FAIL %s idle_busy c=%0d got=%b exp=00", tag, c, {busy_a, busy_b}); end
            n_checks++; if ({ovf_a, ovf_b} !== {m_ovf, m_ovf}) begin n_fail++; $display("FAIL %s ovf c=%0d got=%b exp=%b", tag, c, {ovf_a, ovf_b}, {m_ovf, m_ovf}); end
        end
        en = 1'b1;
    endtask

    // Load v; optionally re-pulse i_load (value ign_v) so it is sampled at edge ign_at.
    task automatic run_load(input string tag, input int v, input int ign_at, input int ign_v);
        int old = m_val;
        bit ovf_exp = (v > 9999);
        @(negedge clk);
        value = 14'(v);
        load  = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            load = (c + 1 == ign_at);
            if (load) value = 14'(ign_v);
            #1;
            n_checks++; if ({busy_a, busy_b} !== 2'b11) begin n_fail++; $display("FAIL %s busy c=%0d got=%b exp=11", tag, c, {busy_a, busy_b}); end
            n_checks++; if (bcd_a !== 4'(exp_digit(old, exp_sel()))) begin n_fail++; $display("FAIL %s stale_bcd c=%0d got=%0d exp=%0d", tag, c, bcd_a, exp_digit(old, exp_sel())); end
            n_checks++; if ({ovf_a, ovf_b} !== {ovf_exp, ovf_exp}) begin n_fail++; $display("FAIL %s ovf_busy c=%0d got=%b exp=%b", tag, c, {ovf_a, ovf_b}, {ovf_exp, ovf_exp}); end
            @(posedge clk);
        end
        @(negedge clk);
        load  = 1'b0;
        m_val = (v > 9999) ? 9999 : v;
        m_ovf = ovf_exp;
        #1;
        n_checks++; if ({busy_a, busy_b} !== 2'b00) begin n_fail++; $display("FAIL %s busy_end got=%b exp=00", tag, {busy_a, busy_b}); end
        n_checks++; if (bcd_a !== 4'(exp_digit(m_val, exp_sel()))) begin n_fail++; $display("FAIL %s new_bcd got=%0d exp=%0d", tag, bcd_a, exp_digit(m_val, exp_sel())); end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0; value = 14'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++; if ({busy_a, busy_b, ovf_a, ovf_b} !== 4'b0000) begin n_fail++; $display("FAIL reset busy_ovf got=%b exp=0000", {busy_a, busy_b, ovf_a, ovf_b}); end
        n_checks++; if ({sel_a, sel_b} !== 4'b0000) begin n_fail++; $display("FAIL reset sel got=%b exp=0000", {sel_a, sel_b}); end
        n_checks++; if ({bcd_a, bcd_b} !== 8'h00) begin n_fail++; $display("FAIL reset bcd got=%h exp=00", {bcd_a, bcd_b}); end
        n_checks++; if ({en_a, en_b} !== 2'b00) begin n_fail++; $display("FAIL reset en_off got=%b exp=00", {en_a, en_b}); end
        en = 1'b1;
        #1;
        n_checks++; if ({en_a, en_b} !== 2'b11) begin n_fail++; $display("FAIL reset en_digit0 got=%b exp=11", {en_a, en_b}); end
        @(negedge clk);
        rst = 1'b0; m_val = 0; m_ovf = 1'b0;
    endtask

    task automatic test_load_1234();
        run_load("load1234", 1234, 0, 0);
        run_scan("scan1234", 20, 1'b0);
    endtask

    task automatic test_scan_div();
        run_scan("scan_div", 32, 1'b0);
    endtask

    task automatic test_blanking();
        run_load("load7", 7, 0, 0);
        run_scan("blank7", 16, 1'b0);
        run_load("load0", 0, 0, 0);
        run_scan("blank0", 16, 1'b0);
        run_load("load90", 90, 0, 0);
        run_scan("blank90", 16, 1'b0);
    endtask

    task automatic test_overflow();
        run_load("load12000", 12000, 0, 0);
        run_scan("ovf_scan", 16, 1'b0);
        run_load("load5", 5, 0, 0);
        run_scan("ovf_clear", 16, 1'b0);
    endtask

    task automatic test_busy_ignore();
        run_load("load4321", 4321, 8, 1111);
        run_scan("ign_busy", 16, 1'b0);
        run_load("load42", 42, 16, 12000);
        run_scan("ign_done", 16, 1'b0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        value = 14'd5678;
        load  = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            load = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; m_val = 0; m_ovf = 1'b0;
        #1;
        n_checks++; if ({busy_a, busy_b} !== 2'b00) begin n_fail++; $display("FAIL rst_mid busy got=%b exp=00", {busy_a, busy_b}); end
        n_checks++; if ({sel_a, sel_b} !== 4'b0000) begin n_fail++; $display("FAIL rst_mid sel got=%b exp=0000", {sel_a, sel_b}); end
        n_checks++; if ({bcd_a, bcd_b} !== 8'h00) begin n_fail++; $display("FAIL rst_mid bcd got=%h exp=00", {bcd_a, bcd_b}); end
        run_scan("rst_mid_scan", 16, 1'b0);
    endtask

    task automatic test_enable();
        run_load("load305", 305, 0, 0);
        run_scan("en_toggle", 24, 1'b1);
        run_scan("en_restore", 16, 1'b0);
    endtask

    task automatic test_random();
        int v;
        for (int i = 0; i < 10; i++) begin
            v = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 9999))
                                             : int'($urandom_range(0, 16383));
            run_load("rand_load", v, 0, 0);
            run_scan("rand_scan", 16, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_load_1234();
        test_scan_div();
        test_blanking();
        test_overflow();
        test_busy_ignore();
        test_reset_mid();
        test_enable();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
